// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: machine word width, the fetch queue entry layout,
// and the NOP that decode substitutes for a squashed instruction.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry register array for the fetch queue: one write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fetch_queue_mem
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  AW      = $clog2(DEPTH),
    parameter type entry_t = fetch_entry_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes and flush on
// taken branch. Define FETCH_QUEUE_BYPASS_EN for a 0-cycle path when empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, bypass, push, pop;
    entry_t        wdata, rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = !full;
    assign out_valid = !empty || bypass;
    assign count     = count_q;

    // A bypassed entry taken by decode the same cycle never enters storage.
    assign pop  = !empty && out_ready && !flush;
    assign push = in_valid && !full && !flush && !(bypass && out_ready);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata.pc    = in_pc;
    assign wdata.instr = in_instr;

    fetch_queue_mem #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .entry_t (entry_t)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (!empty) begin
            out_pc    = rdata.pc;
            out_instr = rdata.instr;
        end else if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

endmodule
